schmidl_cox_metric_gen: RTL and testbench
=========================================

// Module: schmidl_cox_metric_gen
// PURPOSE
// Parametrised Schmidl-Cox timing metric. Computes P(d), the half-symbol autocorrelation, and R(d), the energy,
// over a runtime-selectable half length L. Emits a division-free detection flag, |P|^2 >= thr*R^2.
// Sits between the RX sample stream and the packet detector/CFO stage; replaces the fixed-FFT, divider-based metric.
// PARAMETERS
// DATA_WIDTH    16  signed width of I and Q input components
// MAX_HALF_LEN  512 largest supported L; tap buffer depth = 2*MAX_HALF_LEN
// OUT_WIDTH     16  width of each output field (P_I, P_Q, R)
// THR_WIDTH     16  width of unsigned threshold, fixed point Q(THR_FRAC)
// THR_FRAC      8   fractional bits of threshold
// PORTS
// clk       in  1                clock
// reset     in  1                synchronous, active-high reset
// clear     in  1                synchronous flush; also latches half_len
// half_len  in  clog2(MAX+1)     L; sampled only on reset/clear
// thr       in  THR_WIDTH        detection threshold, sampled every cycle
// i_tdata   in  2*DATA_WIDTH     {I,Q} signed, I in MSBs
// i_tlast   in  1                passed through aligned
// i_tvalid  in  1                input valid
// i_tready  out 1                input ready
// o_tdata   out 3*OUT_WIDTH      {P_I, P_Q, R}; P signed, R unsigned
// o_tuser   out 2                {metric_valid, detect}
// o_tlast   out 1                aligned tlast
// o_tvalid  out 1                output valid
// o_tready  in  1                output ready
// BEHAVIOUR
// - Reset/clear: o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0; clears write pointer, fill count, accumulators and stage valids.
//   Latches L = clamp(half_len, 1, MAX_HALF_LEN). half_len changes at any other time are ignored.
// - Pipeline: 5 stages, one sample/cycle. advance = o_tready | ~o_tvalid; i_tready = advance. All stages hold when advance=0.
//   With no stall, latency is 5 cycles from i accept to o_tvalid. Bubbles propagate; tlast rides with its sample.
//   One output per input sample, in order, with no loss under any o_tready pattern.
// - S1: write x[d] at wr_ptr; read taps x[d-L] and x[d-2L] at (wr_ptr-L) and (wr_ptr-2L), mod 2*MAX_HALF_LEN.
//   Explicit wrap. Read is registered.
// - Fill count saturates at 2L. A tap whose age exceeds the fill count is forced to 0, so sums start exactly from zero.
//   RAM is never zeroed.
// - S2: a = x[d]*conj(x[d-L]); b = x[d-L]*conj(x[d-2L]), each component 2*DATA_WIDTH+1 bits signed.
//   e0 = |x[d]|^2 and e1 = |x[d-L]|^2, each 2*DATA_WIDTH bits unsigned.
// - S3: P += a - b (I and Q separately); R += e0 - e1. ACC_W = 2*DATA_WIDTH+1+clog2(MAX_HALF_LEN+1).
//   R is held in ACC_W and zero-extended so P and R share scale. Full precision, no overflow possible.
// - S4: Ps and Rs = top OUT_WIDTH bits of each accumulator (arithmetic shift by ACC_W-OUT_WIDTH, truncation).
//   Compute |Ps|^2 << THR_FRAC and thr*Rs^2.
// - S5: detect = metric_valid & (Rs != 0) & (|Ps|^2<<THR_FRAC >= thr*Rs^2). Ties detect.
// - metric_valid = fill count reached 2L when this sample was written; 0 for the first 2L-1 outputs after reset/clear.
// - Clear mid-stream: in-flight samples are discarded and not output; the next accepted sample is d=0.
//   Clear takes priority over a simultaneous input handshake.
// - L=MAX_HALF_LEN: the tap at 2L aliases the current write slot and must read the pre-write value (read-before-write).
// STRUCTURE
// - Package sc_metric_pkg: ACC_W/product width functions, tap address wrap function, o_tuser bit index constants.
// - Sub-module sc_tap_ram: circular 2*MAX_HALF_LEN x 2*DATA_WIDTH buffer, one write port, two registered read ports
//   at runtime offsets L/2L, read-before-write; infers BRAM.
// - Top: fill counter, products, accumulators, scaling, compare, stall/valid pipeline.
// TESTING (DATA_WIDTH=16, OUT_WIDTH=16, THR_FRAC=8, MAX_HALF_LEN=16 unless noted)
// 1. L=4, constant x=(16000,0), thr=230 (0.9) -> from the 8th output on: P=(244,0), R=244, o_tuser=2'b11.
//    Before that, metric_valid=0 and detect=0.
// 2. L=4, all-zero input, thr=0 -> R=0, detect=0 on every output.
// 3. L=16, 200 random samples, thr=128 -> every output bit-exact vs golden model; buffer pointer wraps at least 6 times.
// 4. Test 3 with o_tready random 30% and i_tvalid random 50% -> same 200 outputs in order; tlast on sample 199 only.
// 5. Clear after 50 samples with half_len changed 4->8 -> no stale outputs;
//    metric_valid low for next 15 outputs, high on 16th.
// 6. half_len=0 and half_len=31 at clear -> behave as L=1 and L=16; constant input gives P=R after 2 and 32 samples.

Source files
------------

// File: rtl/sc_metric_pkg.sv
// Shared widths, tap address arithmetic and o_tuser field positions for the
// Schmidl-Cox metric generator.
package sc_metric_pkg;

  localparam int TUSER_VALID_BIT  = 1;
  localparam int TUSER_DETECT_BIT = 0;

  // Signed width of one complex product component: x*conj(y) sums two products.
  function automatic int prod_width(input int data_w);
    return 2 * data_w + 1;
  endfunction

  // Accumulator width: a full window of products can never overflow.
  function automatic int acc_width(input int data_w, input int max_half_len);
    return prod_width(data_w) + $clog2(max_half_len + 1);
  endfunction

  // Width of both sides of the division-free comparison.
  function automatic int cmp_width(input int out_w, input int thr_w, input int thr_frac);
    return thr_w + 2 * out_w + thr_frac + 1;
  endfunction

  // Circular address of a tap that is 'offset' samples older than 'ptr'.
  function automatic int tap_addr(input int ptr, input int offset, input int depth);
    return (ptr >= offset) ? ptr - offset : ptr + depth - offset;
  endfunction

endpackage

// File: rtl/sc_tap_ram.sv
// Circular sample buffer: one write port and two registered read ports.
// A read of the slot being written returns the previous contents.
module sc_tap_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  // NOTE: the array has no reset so it maps onto block RAM; stale contents are
  // masked downstream by the fill count instead of being zeroed.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end
  end

endmodule

// File: rtl/schmidl_cox_metric_gen.sv
// Schmidl-Cox timing metric: running P (half-symbol autocorrelation) and R
// (energy) over a runtime half length L, with a division-free detect flag.
module schmidl_cox_metric_gen
  import sc_metric_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_HALF_LEN = 512,
  parameter int OUT_WIDTH    = 16,
  parameter int THR_WIDTH    = 16,
  parameter int THR_FRAC     = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear,
  input  logic [$clog2(MAX_HALF_LEN+1)-1:0]   half_len,
  input  logic [THR_WIDTH-1:0]                thr,
  input  logic [2*DATA_WIDTH-1:0]             i_tdata,
  input  logic                                i_tlast,
  input  logic                                i_tvalid,
  output logic                                i_tready,
  output logic [3*OUT_WIDTH-1:0]              o_tdata,
  output logic [1:0]                          o_tuser,
  output logic                                o_tlast,
  output logic                                o_tvalid,
  input  logic                                o_tready
);

  localparam int HL_W   = $clog2(MAX_HALF_LEN + 1);
  localparam int FILL_W = HL_W + 1;
  localparam int DEPTH  = 2 * MAX_HALF_LEN;
  localparam int AW     = $clog2(DEPTH);
  localparam int E_W    = 2 * DATA_WIDTH;
  localparam int PROD_W = prod_width(DATA_WIDTH);
  localparam int ACC_W  = acc_width(DATA_WIDTH, MAX_HALF_LEN);
  localparam int CMP_W  = cmp_width(OUT_WIDTH, THR_WIDTH, THR_FRAC);

  function automatic logic [HL_W-1:0] clamp_len(input logic [HL_W-1:0] v);
    if (v == '0) return HL_W'(1);
    if (v > HL_W'(MAX_HALF_LEN)) return HL_W'(MAX_HALF_LEN);
    return v;
  endfunction

  logic              advance, accept;
  logic [HL_W-1:0]   half_q;
  logic [FILL_W-1:0] two_l, fill;
  logic [AW-1:0]     wr_ptr, rd_addr_l, rd_addr_2l;
  logic [E_W-1:0]    tap_l, tap_2l;

  assign advance  = o_tready | ~o_tvalid;
  assign i_tready = advance;
  assign accept   = i_tvalid & advance & ~clear & ~reset;
  assign two_l    = {half_q, 1'b0};

  assign rd_addr_l  = AW'(tap_addr(int'(wr_ptr), int'(half_q), DEPTH));
  assign rd_addr_2l = AW'(tap_addr(int'(wr_ptr), int'(two_l), DEPTH));

  sc_tap_ram #(.WIDTH(E_W), .DEPTH(DEPTH), .AW(AW)) u_tap_ram (
    .clk       (clk),
    .we        (accept),
    .wr_addr   (wr_ptr),
    .wr_data   (i_tdata),
    .rd_en     (advance),
    .rd_addr_a (rd_addr_l),
    .rd_addr_b (rd_addr_2l),
    .rd_data_a (tap_l),
    .rd_data_b (tap_2l)
  );

  // Stage registers
  logic                     s1_v, s1_last, s1_mv, s1_en_l, s1_en_2l;
  logic [E_W-1:0]           s1_x;
  logic                     s2_v, s2_last, s2_mv;
  logic signed [PROD_W-1:0] s2_a_i, s2_a_q, s2_b_i, s2_b_q;
  logic [E_W-1:0]           s2_e0, s2_e1;
  logic                     s3_v, s3_last, s3_mv;
  logic signed [ACC_W-1:0]  acc_p_i, acc_p_q;
  logic [ACC_W-1:0]         acc_r;
  logic                     s4_v, s4_last, s4_mv;
  logic [OUT_WIDTH-1:0]     s4_ps_i, s4_ps_q, s4_rs;
  logic [CMP_W-1:0]         s4_mag, s4_thr_r2;

  // Combinational datapath feeding S2 and S4
  logic [E_W-1:0]           tap_l_m, tap_2l_m;
  logic signed [PROD_W-1:0] xi_e, xq_e, li_e, lq_e, mi_e, mq_e;
  logic signed [PROD_W-1:0] a_i, a_q, b_i, b_q;
  logic [E_W-1:0]           e0, e1;
  logic signed [OUT_WIDTH-1:0] ps_i, ps_q;
  logic [OUT_WIDTH-1:0]     rs;
  logic signed [CMP_W-1:0]  pi_c, pq_c, mag_c;
  logic [CMP_W-1:0]         thr_r2;

  // NOTE: every always_comb output is assigned unconditionally, so no latch can form.
  always_comb begin
    tap_l_m  = s1_en_l  ? tap_l  : '0;
    tap_2l_m = s1_en_2l ? tap_2l : '0;
    xi_e = PROD_W'($signed(s1_x[E_W-1 -: DATA_WIDTH]));
    xq_e = PROD_W'($signed(s1_x[DATA_WIDTH-1:0]));
    li_e = PROD_W'($signed(tap_l_m[E_W-1 -: DATA_WIDTH]));
    lq_e = PROD_W'($signed(tap_l_m[DATA_WIDTH-1:0]));
    mi_e = PROD_W'($signed(tap_2l_m[E_W-1 -: DATA_WIDTH]));
    mq_e = PROD_W'($signed(tap_2l_m[DATA_WIDTH-1:0]));
    a_i  = xi_e * li_e + xq_e * lq_e;
    a_q  = xq_e * li_e - xi_e * lq_e;
    b_i  = li_e * mi_e + lq_e * mq_e;
    b_q  = lq_e * mi_e - li_e * mq_e;
    e0   = E_W'(xi_e * xi_e + xq_e * xq_e);
    e1   = E_W'(li_e * li_e + lq_e * lq_e);

    ps_i   = $signed(acc_p_i[ACC_W-1 -: OUT_WIDTH]);
    ps_q   = $signed(acc_p_q[ACC_W-1 -: OUT_WIDTH]);
    rs     = acc_r[ACC_W-1 -: OUT_WIDTH];
    pi_c   = CMP_W'(ps_i);
    pq_c   = CMP_W'(ps_q);
    mag_c  = (pi_c * pi_c + pq_c * pq_c) <<< THR_FRAC;
    thr_r2 = CMP_W'(thr) * CMP_W'(rs) * CMP_W'(rs);
  end

  // NOTE: all state uses non-blocking assignments so every stage samples the
  // previous stage's value from before this edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      half_q   <= clamp_len(half_len);
      wr_ptr   <= '0;
      fill     <= '0;
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s3_v     <= 1'b0;
      s4_v     <= 1'b0;
      acc_p_i  <= '0;
      acc_p_q  <= '0;
      acc_r    <= '0;
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tuser  <= '0;
      o_tlast  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
        if (fill != two_l) fill <= fill + FILL_W'(1);
      end
      if (advance) begin
        // Taps older than the number of samples written read as zero.
        s1_v     <= accept;
        s1_last  <= i_tlast & accept;
        s1_x     <= i_tdata;
        s1_en_l  <= fill >= FILL_W'(half_q);
        s1_en_2l <= fill >= two_l;
        s1_mv    <= fill >= two_l - FILL_W'(1);

        s2_v    <= s1_v;
        s2_last <= s1_last;
        s2_mv   <= s1_mv;
        s2_a_i  <= a_i;
        s2_a_q  <= a_q;
        s2_b_i  <= b_i;
        s2_b_q  <= b_q;
        s2_e0   <= e0;
        s2_e1   <= e1;

        if (s2_v) begin
          acc_p_i <= acc_p_i + ACC_W'(s2_a_i) - ACC_W'(s2_b_i);
          acc_p_q <= acc_p_q + ACC_W'(s2_a_q) - ACC_W'(s2_b_q);
          acc_r   <= acc_r + ACC_W'(s2_e0) - ACC_W'(s2_e1);
        end
        s3_v    <= s2_v;
        s3_last <= s2_last;
        s3_mv   <= s2_mv;

        s4_v      <= s3_v;
        s4_last   <= s3_last;
        s4_mv     <= s3_mv;
        s4_ps_i   <= ps_i;
        s4_ps_q   <= ps_q;
        s4_rs     <= rs;
        s4_mag    <= $unsigned(mag_c);
        s4_thr_r2 <= thr_r2;

        o_tvalid <= s4_v;
        o_tlast  <= s4_last;
        o_tdata  <= {s4_ps_i, s4_ps_q, s4_rs};
        o_tuser[TUSER_VALID_BIT]  <= s4_mv;
        o_tuser[TUSER_DETECT_BIT] <= s4_mv & (s4_rs != '0) & (s4_mag >= s4_thr_r2);
      end
    end
  end

endmodule

// File: tb/tb_schmidl_cox_metric_gen.sv
// Directed bench for schmidl_cox_metric_gen: hand-computed constants plus a
// window-sum reference for random streams, with and without back-pressure.
module tb_schmidl_cox_metric_gen;

  localparam int DW   = 16;
  localparam int MAXL = 16;
  localparam int OW   = 16;
  localparam int TW   = 16;
  localparam int TF   = 8;
  localparam int HLW  = $clog2(MAXL + 1);
  localparam int SH   = (2 * DW + 1 + $clog2(MAXL + 1)) - OW;

  logic            clk = 1'b0;
  logic            reset, clear;
  logic [HLW-1:0]  half_len;
  logic [TW-1:0]   thr;
  logic [2*DW-1:0] i_tdata;
  logic            i_tlast, i_tvalid, i_tready;
  logic [3*OW-1:0] o_tdata;
  logic [1:0]      o_tuser;
  logic            o_tlast, o_tvalid, o_tready;

  always #5 clk = ~clk;

  schmidl_cox_metric_gen #(
    .DATA_WIDTH(DW), .MAX_HALF_LEN(MAXL), .OUT_WIDTH(OW), .THR_WIDTH(TW), .THR_FRAC(TF)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .half_len(half_len), .thr(thr),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] stim     [256];
  logic [47:0] out_data [256];
  logic [1:0]  out_user [256];
  logic        out_last [256];
  int          n_got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: direct window sums with zero for samples before d=0.
  function automatic void model(input int idx, input int l, input int th,
                                output logic [47:0] data, output logic [1:0] user);
    longint pi, pq, r, xi, xq, yi, yq, psi, psq, rs;
    logic   mv, det;
    pi = 0; pq = 0; r = 0;
    for (int k = idx - l + 1; k <= idx; k++) begin
      if (k >= 0) begin
        xi = longint'($signed(stim[k][31:16]));
        xq = longint'($signed(stim[k][15:0]));
        r += xi * xi + xq * xq;
        if (k - l >= 0) begin
          yi = longint'($signed(stim[k-l][31:16]));
          yq = longint'($signed(stim[k-l][15:0]));
          pi += xi * yi + xq * yq;
          pq += xq * yi - xi * yq;
        end
      end
    end
    psi = pi >>> SH;
    psq = pq >>> SH;
    rs  = r >>> SH;
    mv  = (idx + 1 >= 2 * l);
    det = mv && (rs != 0) && (((psi * psi + psq * psq) << TF) >= longint'(th) * rs * rs);
    data = {psi[15:0], psq[15:0], rs[15:0]};
    user = {mv, det};
  endfunction

  task automatic run_stream(input int n, input bit rand_in, input bit rand_out);
    int sent   = 0;
    int cycles = 0;
    n_got = 0;
    while (n_got < n && cycles < n * 20 + 100) begin
      @(negedge clk);
      i_tvalid = (sent < n) && (!rand_in || ($urandom_range(0, 1) == 1));
      i_tdata  = (sent < n) ? stim[sent] : '0;
      i_tlast  = (sent == n - 1);
      o_tready = !rand_out || ($urandom_range(0, 9) >= 3);
      #1;
      if (o_tvalid && o_tready) begin
        out_data[n_got] = o_tdata;
        out_user[n_got] = o_tuser;
        out_last[n_got] = o_tlast;
        n_got++;
      end
      if (i_tvalid && i_tready) sent++;
      cycles++;
    end
    check("stream_count", 64'(n_got), 64'(n));
    @(negedge clk);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;
  endtask

  task automatic compare_stream(input int n, input int l, input int th, input string tag);
    logic [47:0] d;
    logic [1:0]  u;
    for (int i = 0; i < n; i++) begin
      model(i, l, th, d, u);
      check($sformatf("%s_data[%0d]", tag, i), 64'(out_data[i]), 64'(d));
      check($sformatf("%s_user[%0d]", tag, i), 64'(out_user[i]), 64'(u));
      check($sformatf("%s_last[%0d]", tag, i), 64'(out_last[i]), 64'(i == n - 1));
    end
  endtask

  task automatic do_clear(input logic [HLW-1:0] hl);
    @(negedge clk);
    i_tvalid = 1'b0;
    clear    = 1'b1;
    half_len = hl;
    @(negedge clk);
    clear    = 1'b0;
    check("clear_tvalid", 64'(o_tvalid), 64'(0));
    check("clear_tdata", 64'(o_tdata), 64'(0));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; half_len = 5'd4; thr = 16'd230;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", 64'(o_tvalid), 64'(0));
    check("rst_tdata", 64'(o_tdata), 64'(0));
    check("rst_tuser", 64'(o_tuser), 64'(0));
    check("rst_tlast", 64'(o_tlast), 64'(0));
    check("rst_tready", 64'(i_tready), 64'(1));
    reset = 1'b0;

    // 1: L=4, constant (16000,0): 4*16000^2 >> 22 = 244 once the window is full
    for (int i = 0; i < 16; i++) stim[i] = {16'sd16000, 16'sd0};
    run_stream(16, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i >= 7) begin
        check($sformatf("t1_full_data[%0d]", i), 64'(out_data[i]), 64'h00F4_0000_00F4);
        check($sformatf("t1_full_user[%0d]", i), 64'(out_user[i]), 64'(2'b11));
      end else begin
        check($sformatf("t1_early_user[%0d]", i), 64'(out_user[i]), 64'(2'b00));
      end
    end
    compare_stream(16, 4, 230, "t1");

    // 2: all-zero input, thr=0: R stays 0 and detect never fires
    do_clear(5'd4);
    thr = 16'd0;
    for (int i = 0; i < 12; i++) stim[i] = '0;
    run_stream(12, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t2_r[%0d]", i), 64'(out_data[i][15:0]), 64'(0));
      check($sformatf("t2_det[%0d]", i), 64'(out_user[i][0]), 64'(0));
    end

    // 3: L=16, 200 random samples, free-flowing
    do_clear(5'd16);
    thr = 16'd128;
    for (int i = 0; i < 200; i++) stim[i] = $urandom;
    run_stream(200, 1'b0, 1'b0);
    compare_stream(200, 16, 128, "t3");

    // 4: same stream with random input gaps and output stalls
    do_clear(5'd16);
    run_stream(200, 1'b1, 1'b1);
    compare_stream(200, 16, 128, "t4");

    // 5: 50 samples at L=4 left in flight, then clear to L=8
    do_clear(5'd4);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      i_tvalid = 1'b1;
      i_tdata  = stim[i];
      i_tlast  = 1'b0;
      o_tready = 1'b1;
    end
    do_clear(5'd8);
    run_stream(20, 1'b0, 1'b0);
    compare_stream(20, 8, 128, "t5");
    for (int i = 0; i < 20; i++)
      check($sformatf("t5_mv[%0d]", i), 64'(out_user[i][1]), 64'(i >= 15));
    repeat (8) @(negedge clk);
    check("t5_no_extra", 64'(o_tvalid), 64'(0));

    // 6: half_len=0 acts as L=1; 16000^2 >> 22 = 61
    do_clear(5'd0);
    thr = 16'd230;
    for (int i = 0; i < 40; i++) stim[i] = {16'sd16000, 16'sd0};
    run_stream(6, 1'b0, 1'b0);
    check("t6a_first", 64'(out_data[0]), 64'h0000_0000_003D);
    for (int i = 1; i < 6; i++)
      check($sformatf("t6a_data[%0d]", i), 64'(out_data[i]), 64'h003D_0000_003D);
    compare_stream(6, 1, 230, "t6a");

    // half_len=31 clamps to L=16: 16*16000^2 >> 22 = 976, 15 terms give 915
    do_clear(5'd31);
    run_stream(40, 1'b0, 1'b0);
    check("t6b_partial_p", 64'(out_data[30][47:32]), 64'h0393);
    for (int i = 31; i < 40; i++)
      check($sformatf("t6b_data[%0d]", i), 64'(out_data[i]), 64'h03D0_0000_03D0);
    compare_stream(40, 16, 230, "t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
